busy_scoreboard: RTL

Parametrised register busy scoreboard for the decode/dispatch stage of the superscalar core. It tracks, per architectural register, whether an in-flight producer has yet to deliver its result, and reports source readiness for a dispatch group of configurable width. It handles intra-group RAW hazards internally, and can take branch checkpoints of the table for single-cycle misprediction recovery. It sits beside the rename/map logic and is written by the map, select (early wakeup) and writeback stages.

---
 rtl/busy_scoreboard_if.sv | 48 ++++
 rtl/busy_scoreboard.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/busy_scoreboard_if.sv
// busy_scoreboard_if
//   Bundles every non-clock/reset signal of the register busy scoreboard.
//   master : the map/select/writeback side that drives requests
//   slave  : the scoreboard itself
// Signals:
//   flush                    synchronous pipeline flush
//   map_we / map_dest        per-slot destination writes (slot 0 oldest)
//   rd_src / rd_ready        2 sources per slot, index 2i+s; combinational readiness
//   wake_valid / wake_dest   wakeup (clear) ports
//   ckpt_alloc, ckpt_release, ckpt_restore, ckpt_restore_id   checkpoint controls
//   ckpt_alloc_id, ckpt_full                                  checkpoint status
//   busy_cnt                 registered popcount of the busy table
interface busy_scoreboard_if #(
  parameter int REG_NUM    = 32,
  parameter int MAP_WIDTH  = 2,
  parameter int WAKE_PORTS = 4,
  parameter int CKPT_NUM   = 4,
  parameter int ADDR_W     = $clog2(REG_NUM),
  parameter int CKPT_W     = $clog2(CKPT_NUM),
  parameter int CNT_W      = $clog2(REG_NUM) + 1
);
  logic                            flush;
  logic [MAP_WIDTH-1:0]            map_we;
  logic [MAP_WIDTH*ADDR_W-1:0]     map_dest;
  logic [2*MAP_WIDTH*ADDR_W-1:0]   rd_src;
  logic [2*MAP_WIDTH-1:0]          rd_ready;
  logic [WAKE_PORTS-1:0]           wake_valid;
  logic [WAKE_PORTS*ADDR_W-1:0]    wake_dest;
  logic                            ckpt_alloc;
  logic [CKPT_W-1:0]               ckpt_alloc_id;
  logic                            ckpt_full;
  logic                            ckpt_release;
  logic                            ckpt_restore;
  logic [CKPT_W-1:0]               ckpt_restore_id;
  logic [CNT_W-1:0]                busy_cnt;

  modport master (
    output flush, map_we, map_dest, rd_src, wake_valid, wake_dest,
           ckpt_alloc, ckpt_release, ckpt_restore, ckpt_restore_id,
    input  rd_ready, ckpt_alloc_id, ckpt_full, busy_cnt
  );

  modport slave (
    input  flush, map_we, map_dest, rd_src, wake_valid, wake_dest,
           ckpt_alloc, ckpt_release, ckpt_restore, ckpt_restore_id,
    output rd_ready, ckpt_alloc_id, ckpt_full, busy_cnt
  );
endinterface

// File: rtl/busy_scoreboard.sv
// busy_scoreboard
//   Per-architectural-register busy table for decode/dispatch. Reports source
//   readiness for a dispatch group (with write-first wakeup bypass and
//   intra-group RAW detection) and optionally keeps a FIFO of table
//   checkpoints for single-cycle mispredict recovery.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     busy_scoreboard_if.slave (map, read, wakeup, checkpoint, count)
// Configuration:
//   BUSY_SCOREBOARD_CKPT_EN  defined   -> checkpoint FIFO, snapshots and restore built
//                            undefined -> checkpoint controls ignored, full/id tied 0
module busy_scoreboard #(
  parameter int REG_NUM    = 32,
  parameter int ADDR_W     = $clog2(REG_NUM),
  parameter int MAP_WIDTH  = 2,
  parameter int WAKE_PORTS = 4,
  parameter int CKPT_NUM   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  busy_scoreboard_if.slave bus
);
  localparam int CKPT_W = $clog2(CKPT_NUM);
  localparam int CNT_W  = $clog2(REG_NUM) + 1;

  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   set_vec;
  logic [REG_NUM-1:0]   clr_vec;
  logic [REG_NUM-1:0]   table_next;
  logic [2*MAP_WIDTH-1:0] ready_c;
  logic [ADDR_W-1:0]    src_sel;
  logic                 hazard;
  logic [CNT_W-1:0]     pop_c;
  logic [CNT_W-1:0]     cnt_q;

  // Decode this cycle's map (set) and wakeup (clear) requests into bit vectors.
  // Register 0 can never become busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < MAP_WIDTH; i++)
      if (bus.map_we[i]) set_vec[bus.map_dest[i*ADDR_W +: ADDR_W]] = 1'b1;
    for (int p = 0; p < WAKE_PORTS; p++)
      if (bus.wake_valid[p]) clr_vec[bus.wake_dest[p*ADDR_W +: ADDR_W]] = 1'b1;
    set_vec[0] = 1'b0;
  end

  // Set is ORed in after the clear so a new producer owns the register.
  assign table_next = (busy_q & ~clr_vec) | set_vec;

  // Readiness: a source waits on a table bit not being woken this cycle, or on
  // an older slot of the same group that writes it.
  always_comb begin
    ready_c = '0;
    src_sel = '0;
    hazard  = 1'b0;
    for (int i = 0; i < MAP_WIDTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        src_sel = bus.rd_src[(2*i+s)*ADDR_W +: ADDR_W];
        hazard  = busy_q[src_sel] & ~clr_vec[src_sel];
        for (int k = 0; k < i; k++)
          if (bus.map_we[k] && (bus.map_dest[k*ADDR_W +: ADDR_W] == src_sel)) hazard = 1'b1;
        ready_c[2*i+s] = (src_sel == '0) || !hazard;
      end
    end
  end

  assign bus.rd_ready = ready_c;

  always_comb begin
    pop_c = '0;
    for (int r = 0; r < REG_NUM; r++) pop_c = pop_c + CNT_W'(busy_q[r]);
  end

  // The count lags the table by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= pop_c;
  end

  assign bus.busy_cnt = cnt_q;

`ifdef BUSY_SCOREBOARD_CKPT_EN
  logic [REG_NUM-1:0] snap_q [CKPT_NUM];
  logic [CKPT_W-1:0]  head_q;
  logic [CKPT_W-1:0]  tail_q;
  logic [CKPT_W:0]    count_q;
  logic               full_c;
  logic               do_alloc;
  logic               do_release;
  logic [CKPT_W-1:0]  head_next;
  logic [CKPT_W-1:0]  restore_off;
  logic               restore_id_ok;

  assign full_c      = (count_q == (CKPT_W+1)'(CKPT_NUM));
  assign do_alloc    = bus.ckpt_alloc && !full_c && !bus.ckpt_restore;
  assign do_release  = bus.ckpt_release && (count_q != '0);
  assign head_next   = do_release ? head_q + CKPT_W'(1) : head_q;
  // Surviving checkpoints after a restore are those between the (possibly
  // advanced) head and the restored id; power-of-two depth makes this wrap.
  assign restore_off = bus.ckpt_restore_id - head_next;
  assign restore_id_ok = ({1'b0, bus.ckpt_restore_id - head_q} < count_q);

  // Table, snapshots and FIFO pointers. Wakeups scrub every snapshot slot;
  // freed slots are rewritten on allocation so scrubbing them is harmless.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int j = 0; j < CKPT_NUM; j++) snap_q[j] <= '0;
    end else if (bus.flush) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int j = 0; j < CKPT_NUM; j++) snap_q[j] <= snap_q[j] & ~clr_vec;
      if (bus.ckpt_restore) begin
        busy_q  <= snap_q[bus.ckpt_restore_id] & ~clr_vec;
        tail_q  <= bus.ckpt_restore_id;
        count_q <= {1'b0, restore_off};
      end else begin
        busy_q <= table_next;
        if (do_alloc) begin
          snap_q[tail_q] <= table_next;
          tail_q         <= tail_q + CKPT_W'(1);
        end
        count_q <= count_q + (CKPT_W+1)'(do_alloc) - (CKPT_W+1)'(do_release);
      end
      head_q <= head_next;
    end
  end

  assign bus.ckpt_full     = full_c;
  assign bus.ckpt_alloc_id = tail_q;

  restore_valid_a: assert property (@(posedge clk) disable iff (!resetn)
    (bus.ckpt_restore && !bus.flush) |-> restore_id_ok);

  restore_head_release_a: assert property (@(posedge clk) disable iff (!resetn)
    (bus.ckpt_restore && bus.ckpt_release && !bus.flush) |-> (bus.ckpt_restore_id != head_q));
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{bus.ckpt_alloc, bus.ckpt_release, bus.ckpt_restore, bus.ckpt_restore_id};

  // Without checkpoints the table only follows maps, wakeups and flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        busy_q <= '0;
    else if (bus.flush) busy_q <= '0;
    else                busy_q <= table_next;
  end

  assign bus.ckpt_full     = 1'b0;
  assign bus.ckpt_alloc_id = '0;
`endif
endmodule
